hmc_tx_token_arbiter: RTL and testbench
=======================================

Name: hmc_tx_token_arbiter

Overview:
- Shares the HMC TX packet path between NUM_REQ requesters using round-robin arbitration.
- Gates each grant on HMC input-buffer tokens: one token per FLIT.
- Sits between the request sources (user AXI-side packets, link-internal packets) and the TX link framing stage.
- Keeps the token count from the configured initial value, charges each granted packet and credits returned tokens.

Parameters:
- LOG_MAX_HMC_TOKENS, 10, width of the token counter; max count 2**LOG_MAX_HMC_TOKENS-1.
- NUM_REQ, 2, number of requesters (2..8).
- LEN_W, 4, packet-length field width in FLITs; legal lengths 1..9.
- RTC_W, 5, width of the returned-token field.

Ports:
- clk_hmc  in  1  clock; all logic on rising edge.
- res_hmc  in  1  synchronous active-high reset.
- cfg_init_tokens  in  LOG_MAX_HMC_TOKENS  token load value.
- cfg_load  in  1  pulse: load tokens, clear error, enter RUN.
- req_valid  in  NUM_REQ  per-requester packet pending.
- req_len  in  NUM_REQ*LEN_W  per-requester packet length; requester i at bits [i*LEN_W +: LEN_W].
- req_ready  out  NUM_REQ  one-hot grant, combinational; the transfer occurs when req_valid[i] and req_ready[i] are both high.
- tx_valid  out  1  output register holds a granted packet.
- tx_sel  out  max(1,$clog2(NUM_REQ))  index of the granted requester.
- tx_len  out  LEN_W  length of the granted packet.
- tx_ready  in  1  downstream accepts the packet.
- tok_ret_valid  in  1  token return strobe.
- tok_ret_cnt  in  RTC_W  number of tokens returned.
- tokens_avail  out  LOG_MAX_HMC_TOKENS  current token count (registered).
- state  out  2  00=IDLE, 01=RUN, 10=ERR.
- err  out  1  sticky: overflow or illegal length.

Behaviour:
Reset (res_hmc=1 at a clock edge; takes priority over everything, including mid-packet):
- state=IDLE, tokens_avail=0, req_ready=0, tx_valid=0, tx_sel=0, tx_len=0, err=0.
- Round-robin pointer=0.
- Any pending output packet is dropped.

IDLE:
- No grants; token returns are ignored.
- cfg_load=1: tokens <= cfg_init_tokens; next state RUN.

RUN:
- The output register is free when tx_valid=0 or (tx_valid & tx_ready).
- Candidate = first i with req_valid[i]=1, searching from the pointer upward with wrap.
- Grant (req_ready[candidate]=1) only if the output register is free, cfg_load=0, and 1 <= len <= 9 and len <= tokens_avail.
- Eligibility uses the registered count only; same-cycle returns do not count.
- If the candidate lacks tokens: no grant to any requester this cycle. This is strict round-robin with no bypass, so large packets cannot starve.
- Candidate length 0 or >9: no grant; err=1; next state ERR.
- On grant in cycle N: tx_valid=1, tx_sel, tx_len registered at N+1; pointer <= candidate+1 mod NUM_REQ.
- Token update: tokens_next = tokens - (grant ? len : 0) + (tok_ret_valid ? tok_ret_cnt : 0).
- The subtraction cannot underflow because a grant requires len <= tokens.
- If the sum exceeds 2**LOG_MAX_HMC_TOKENS-1: saturate at the max value, err=1, next state ERR.
- tx_valid & !tx_ready: tx_sel and tx_len held stable; no new grant.
- tx_valid & tx_ready with no new grant: tx_valid=0 next cycle.
- cfg_load=1 in RUN: tokens <= cfg_init_tokens; returns and grants in that cycle are discarded. The pending output packet is unaffected.

ERR:
- No grants; token returns are ignored.
- The pending tx packet still drains normally on tx_ready.
- Exit only via reset, or via cfg_load, which reloads tokens, clears err and enters RUN.

Arithmetic:
- Internal sum is LOG_MAX_HMC_TOKENS+1 bits, then saturated to LOG_MAX_HMC_TOKENS bits.

Test Plan:
- Reset, then cfg_load with cfg_init_tokens=16 -> next cycle state=01, tokens_avail=16, err=0; before the load, req_valid=11 gives req_ready=00.
- tokens=16, both requesters valid with len=4, tx_ready=1 -> grants 0,1,0,1 on consecutive cycles; tokens_avail 12,8,4,0; then req_ready=00 with tx_valid falling to 0 one cycle later.
- tokens=3, req0 len=4, req1 len=1 -> no grant (req1 is not bypassed); tok_ret_valid=1 with tok_ret_cnt=2 -> tokens=5 next cycle, req0 granted the following cycle, tokens=1.
- tx_ready=0 after a grant with len=2 from req1 -> tx_valid=1, tx_sel=1, tx_len=2 held stable; no further grants; tokens unchanged; tx_ready=1 -> a grant resumes the same cycle.
- tokens=1020, return 8 -> tokens_avail=1023, err=1, state=10, grants stop; cfg_load with 100 -> state=01, tokens=100, err=0.
- Reset while tx_valid=1 with tokens=50 -> next cycle tx_valid=0, tokens_avail=0, state=00, pointer=0; req1 len=0 after reload -> err=1, state=10.

Source files
------------

// File: rtl/hmc_tx_token_arbiter.sv
// hmc_tx_token_arbiter: round-robin TX arbiter that gates grants on HMC input-buffer tokens
module hmc_tx_token_arbiter #(
  parameter int LOG_MAX_HMC_TOKENS = 10,
  parameter int NUM_REQ = 2,
  parameter int LEN_W = 4,
  parameter int RTC_W = 5,
  localparam int SEL_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic clk_hmc,
  input  logic res_hmc,
  input  logic [LOG_MAX_HMC_TOKENS-1:0] cfg_init_tokens,
  input  logic cfg_load,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0] req_ready,
  output logic tx_valid,
  output logic [SEL_W-1:0] tx_sel,
  output logic [LEN_W-1:0] tx_len,
  input  logic tx_ready,
  input  logic tok_ret_valid,
  input  logic [RTC_W-1:0] tok_ret_cnt,
  output logic [LOG_MAX_HMC_TOKENS-1:0] tokens_avail,
  output logic [1:0] state,
  output logic err
);
  localparam int TW = LOG_MAX_HMC_TOKENS + 1;
  localparam logic [TW-1:0] MAX_TOK = {1'b0, {LOG_MAX_HMC_TOKENS{1'b1}}};
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, ERR = 2'b10} st_t;
  st_t st;
  logic [SEL_W-1:0] ptr, cand, idx;
  logic found, grant, len_bad, ovf;
  logic [LEN_W-1:0] cand_len;
  logic [TW-1:0] sum;
  always_comb begin
    cand = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        cand = idx;
      end
    end
  end
  assign cand_len = req_len[int'(cand)*LEN_W +: LEN_W];
  assign len_bad = found && (cand_len == '0 || cand_len > LEN_W'(9));
  // strict round-robin: a starved candidate blocks everyone rather than being bypassed
  assign grant = st == RUN && !cfg_load && found && (!tx_valid || tx_ready) && !len_bad &&
                 LOG_MAX_HMC_TOKENS'(cand_len) <= tokens_avail;
  assign req_ready = {{(NUM_REQ-1){1'b0}}, grant} << cand;
  assign sum = {1'b0, tokens_avail} - (grant ? TW'(cand_len) : '0) +
               (tok_ret_valid ? TW'(tok_ret_cnt) : '0);
  assign ovf = sum > MAX_TOK;
  assign state = st;
  always_ff @(posedge clk_hmc) begin
    if (res_hmc) begin
      st <= IDLE;
      tokens_avail <= '0;
      ptr <= '0;
      err <= 1'b0;
      tx_valid <= 1'b0;
      tx_sel <= '0;
      tx_len <= '0;
    end else begin
      if (grant) begin
        tx_valid <= 1'b1;
        tx_sel <= cand;
        tx_len <= cand_len;
        ptr <= SEL_W'((int'(cand) + 1) % NUM_REQ);
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (cfg_load) begin
        tokens_avail <= cfg_init_tokens;
        err <= 1'b0;
        st <= RUN;
      end else if (st == RUN) begin
        tokens_avail <= ovf ? '1 : sum[LOG_MAX_HMC_TOKENS-1:0];
        if (ovf || len_bad) begin
          err <= 1'b1;
          st <= ERR;
        end
      end
    end
  end
endmodule

// File: tb/tb_hmc_tx_token_arbiter.sv
// tb_hmc_tx_token_arbiter: directed scenarios plus randomized traffic against a cycle model
module tb_hmc_tx_token_arbiter;
  localparam int N = 2;
  localparam int LW = 4;
  localparam int TKW = 10;
  localparam int RW = 5;
  localparam int MAXT = 1023;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic res_hmc = 1'b1, cfg_load = 1'b0, tx_ready = 1'b0, tok_ret_valid = 1'b0;
  logic [TKW-1:0] cfg_init_tokens = '0;
  logic [N-1:0] req_valid = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [RW-1:0] tok_ret_cnt = '0;
  logic [N-1:0] req_ready;
  logic tx_valid, err;
  logic [0:0] tx_sel;
  logic [LW-1:0] tx_len;
  logic [TKW-1:0] tokens_avail;
  logic [1:0] state;
  int total = 0, bad = 0;
  int m_state, m_tok, m_ptr, m_sel, m_len;
  bit m_err, m_tv;

  hmc_tx_token_arbiter dut (
    .clk_hmc(clk), .res_hmc(res_hmc), .cfg_init_tokens(cfg_init_tokens), .cfg_load(cfg_load),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_sel(tx_sel), .tx_len(tx_len), .tx_ready(tx_ready), .tok_ret_valid(tok_ret_valid),
    .tok_ret_cnt(tok_ret_cnt), .tokens_avail(tokens_avail), .state(state), .err(err)
  );

  function automatic int m_cand();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int m_lenof(int c);
    return c < 0 ? 0 : int'(req_len[c*LW +: LW]);
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r = '0;
    int c = m_cand();
    int l = m_lenof(c);
    if (c < 0 || m_state != 1 || cfg_load || (m_tv && !tx_ready)) return r;
    if (l < 1 || l > 9 || l > m_tok) return r;
    r[c] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    logic [N-1:0] g = m_ready();
    int c = m_cand();
    int l = m_lenof(c);
    int s;
    @(posedge clk);
    if (res_hmc) begin
      m_state = 0; m_tok = 0; m_ptr = 0; m_err = 0; m_tv = 0; m_sel = 0; m_len = 0;
    end else begin
      if (g != 0) begin
        m_tv = 1; m_sel = c; m_len = l; m_ptr = (c + 1) % N;
      end else if (tx_ready) m_tv = 0;
      if (cfg_load) begin
        m_tok = cfg_init_tokens; m_err = 0; m_state = 1;
      end else if (m_state == 1) begin
        s = m_tok - (g != 0 ? l : 0) + (tok_ret_valid ? int'(tok_ret_cnt) : 0);
        if (c >= 0 && (l < 1 || l > 9)) begin m_err = 1; m_state = 2; end
        if (s > MAXT) begin s = MAXT; m_err = 1; m_state = 2; end
        m_tok = s;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    res_hmc = 1'b1; req_valid = 2'b11; req_len = {4'd1, 4'd1};
    tick(); tick();
    res_hmc = 1'b0;
    #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", state); end
    total++; if (tokens_avail !== '0) begin bad++; $display("FAIL reset_tokens got=%0d exp=0", tokens_avail); end
    total++; if ({tx_valid, tx_sel, tx_len, err} !== 7'd0) begin bad++; $display("FAIL reset_tx got=%b exp=0", {tx_valid, tx_sel, tx_len, err}); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL idle_ready got=%b exp=00", req_ready); end
    req_valid = '0; cfg_load = 1'b1; cfg_init_tokens = 10'd16;
    tick();
    cfg_load = 1'b0;
    total++; if ({state, tokens_avail, err} !== {2'b01, 10'd16, 1'b0}) begin bad++; $display("FAIL load got=%b/%0d/%b exp=01/16/0", state, tokens_avail, err); end
  endtask

  task automatic test_round_robin();
    req_valid = 2'b11; req_len = {4'd4, 4'd4}; tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (req_ready !== (k % 2 ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_ready%0d got=%b exp=%b", k, req_ready, k % 2 ? 2'b10 : 2'b01); end
      tick();
      total++; if (tokens_avail !== 10'(12 - 4*k)) begin bad++; $display("FAIL rr_tokens%0d got=%0d exp=%0d", k, tokens_avail, 12 - 4*k); end
      total++; if ({tx_valid, tx_sel} !== {1'b1, 1'(k % 2)}) begin bad++; $display("FAIL rr_sel%0d got=%b exp=1%0d", k, {tx_valid, tx_sel}, k % 2); end
    end
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rr_empty got=%b exp=00", req_ready); end
    tick();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", tx_valid); end
  endtask

  task automatic test_no_bypass();
    cfg_load = 1'b1; cfg_init_tokens = 10'd3; req_len = {4'd1, 4'd4};
    tick();
    cfg_load = 1'b0;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL nobypass_ready got=%b exp=00", req_ready); end
    tok_ret_valid = 1'b1; tok_ret_cnt = 5'd2;
    tick();
    tok_ret_valid = 1'b0;
    total++; if (tokens_avail !== 10'd5) begin bad++; $display("FAIL ret_tokens got=%0d exp=5", tokens_avail); end
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL ret_grant got=%b exp=01", req_ready); end
    tick();
    total++; if (tokens_avail !== 10'd1) begin bad++; $display("FAIL ret_charge got=%0d exp=1", tokens_avail); end
  endtask

  task automatic test_backpressure();
    cfg_load = 1'b1; cfg_init_tokens = 10'd16; req_valid = '0; tx_ready = 1'b1;
    tick();
    cfg_load = 1'b0; req_valid = 2'b10; req_len = {4'd2, 4'd4}; tx_ready = 1'b0;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_grant got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_stall%0d got=%b exp=00", k, req_ready); end
      tick();
      total++; if ({tx_valid, tx_sel, tx_len, tokens_avail} !== {1'b1, 1'b1, 4'd2, 10'd14}) begin bad++; $display("FAIL bp_hold%0d got=%b/%b/%0d/%0d exp=1/1/2/14", k, tx_valid, tx_sel, tx_len, tokens_avail); end
    end
    tx_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_resume got=%b exp=01", req_ready); end
    tick();
    total++; if ({tx_sel, tx_len, tokens_avail} !== {1'b0, 4'd4, 10'd10}) begin bad++; $display("FAIL bp_next got=%b/%0d/%0d exp=0/4/10", tx_sel, tx_len, tokens_avail); end
  endtask

  task automatic test_overflow();
    cfg_load = 1'b1; cfg_init_tokens = 10'd1020; req_valid = '0;
    tick();
    cfg_load = 1'b0; tok_ret_valid = 1'b1; tok_ret_cnt = 5'd8;
    tick();
    tok_ret_valid = 1'b0;
    total++; if ({tokens_avail, err, state} !== {10'd1023, 1'b1, 2'b10}) begin bad++; $display("FAIL ovf got=%0d/%b/%b exp=1023/1/10", tokens_avail, err, state); end
    req_valid = 2'b11; req_len = {4'd1, 4'd1};
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL err_ready got=%b exp=00", req_ready); end
    cfg_load = 1'b1; cfg_init_tokens = 10'd100;
    tick();
    cfg_load = 1'b0;
    total++; if ({state, tokens_avail, err} !== {2'b01, 10'd100, 1'b0}) begin bad++; $display("FAIL reload got=%b/%0d/%b exp=01/100/0", state, tokens_avail, err); end
  endtask

  task automatic test_reset_mid();
    cfg_load = 1'b1; cfg_init_tokens = 10'd52; req_valid = '0; tx_ready = 1'b1;
    tick();
    cfg_load = 1'b0; req_valid = 2'b01; req_len = {4'd1, 4'd2}; tx_ready = 1'b0;
    tick();
    req_valid = '0;
    total++; if ({tx_valid, tokens_avail} !== {1'b1, 10'd50}) begin bad++; $display("FAIL pre_reset got=%b/%0d exp=1/50", tx_valid, tokens_avail); end
    res_hmc = 1'b1;
    tick();
    res_hmc = 1'b0;
    total++; if ({tx_valid, tokens_avail, state, err} !== {1'b0, 10'd0, 2'b00, 1'b0}) begin bad++; $display("FAIL mid_reset got=%b/%0d/%b/%b exp=0/0/00/0", tx_valid, tokens_avail, state, err); end
    cfg_load = 1'b1; cfg_init_tokens = 10'd16;
    tick();
    cfg_load = 1'b0; req_valid = 2'b11; tx_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL ptr_reset got=%b exp=01", req_ready); end
    req_valid = 2'b10; req_len = {4'd0, 4'd1};
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL badlen_ready got=%b exp=00", req_ready); end
    tick();
    req_valid = '0;
    total++; if ({err, state} !== {1'b1, 2'b10}) begin bad++; $display("FAIL badlen got=%b/%b exp=1/10", err, state); end
  endtask

  task automatic test_random();
    logic [18:0] exp_r;
    for (int n = 0; n < 3000; n++) begin
      res_hmc = $urandom_range(0, 199) == 0;
      cfg_load = $urandom_range(0, 29) == 0;
      cfg_init_tokens = $urandom_range(0, 9) == 0 ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 40));
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++)
        req_len[i*LW +: LW] = $urandom_range(0, 49) == 0 ? LW'($urandom_range(10, 15) % 16 * ($urandom_range(0, 1))) : LW'($urandom_range(1, 9));
      tx_ready = $urandom_range(0, 9) < 7;
      tok_ret_valid = $urandom_range(0, 9) < 3;
      tok_ret_cnt = RW'($urandom);
      #1;
      total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready%0d got=%b exp=%b", n, req_ready, m_ready()); end
      tick();
      exp_r = {1'(m_tv), 1'(m_sel), 4'(m_len), 10'(m_tok), 2'(m_state), m_err};
      total++; if ({tx_valid, tx_sel, tx_len, tokens_avail, state, err} !== exp_r) begin bad++; $display("FAIL rnd_regs%0d got=%h exp=%h", n, {tx_valid, tx_sel, tx_len, tokens_avail, state, err}, exp_r); end
    end
  endtask

  initial begin
    m_state = 0; m_tok = 0; m_ptr = 0; m_err = 0; m_tv = 0; m_sel = 0; m_len = 0;
    #2;
    test_reset();
    test_round_robin();
    test_no_bypass();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
